scope_capture_buffer: RTL
=========================

Name: scope_capture_buffer

Overview:
Parametrised, multi-channel, triggered ping-pong sample buffer for the oscilloscope display path. It decimates incoming ADC samples and arms a trigger (free-run, rising or falling edge with auto-timeout) on a selectable channel. It captures DEPTH samples per channel into the write bank, then flips banks only on a frame-boundary pulse so the VGA renderer never reads a half-written trace. It sits between the sample source and the VGA pixel generator, which reads the display bank by column address.

Parameters:
NCH, 2, number of channels captured in lockstep
SAMPLE_W, 9, bits per channel sample
DEPTH, 640, samples per channel per capture (one per display column)
ADDR_W, 10, read/write address width; must satisfy 2**ADDR_W >= DEPTH
AUTO_TO, 2048, accepted samples without trigger before a forced trigger in edge modes

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sample_valid  in  1  sample_data is valid this cycle
sample_data  in  NCH*SAMPLE_W  channel k occupies bits [k*SAMPLE_W +: SAMPLE_W]
trig_mode  in  2  00 free-run, 01 rising, 10 falling, 11 treated as free-run
trig_ch  in  $clog2(NCH) (min 1)  channel compared against trig_level
trig_level  in  SAMPLE_W  unsigned trigger threshold
decim  in  8  keep 1 of every decim+1 valid samples
frame_swap  in  1  one-cycle pulse at display frame boundary (vblank)
rd_addr  in  ADDR_W  display-bank column address
rd_data  out  NCH*SAMPLE_W  display-bank data, 1-cycle read latency
full  out  1  write bank complete, awaiting frame_swap
waiting  out  1  armed, searching for trigger
auto_trig  out  1  last capture was forced by timeout
overrun  out  1  sticky: accepted sample dropped while full

Behaviour:
- Reset values: state=WAIT_TRIG; write bank=1, display bank=0; full=0; waiting=1; auto_trig=0; overrun=0; rd_data=0; decimation counter, timeout counter, write address and prev_valid=0. RAM contents are not reset. Reset mid-capture abandons the capture.
- Decimation: the counter increments on each sample_valid. A sample is "accepted" when counter==decim latched, after which the counter returns to 0. decim=0 accepts every valid sample. The counter clears on every entry to WAIT_TRIG.
- Config latch: trig_mode, trig_ch, trig_level and decim are registered on every entry to WAIT_TRIG (including reset). Changes made mid-capture take effect on the next arm.
- WAIT_TRIG:
  - Rising trigger on an accepted sample s when prev_valid and prev<trig_level and s>=trig_level.
  - Falling trigger when prev_valid and prev>=trig_level and s<trig_level.
  - Free-run triggers on the first accepted sample.
  - Comparisons are unsigned, on the latched trig_ch.
  - prev updates on each accepted sample; prev_valid sets after the first one.
  - The timeout counter counts accepted samples; when it reaches AUTO_TO-1 without a trigger, that sample forces a trigger and auto_trig=1. A genuine trigger sets auto_trig=0.
  - The triggering sample is written at address 0 of the write bank. The state moves to CAPTURE with write address=1 and waiting=0.
- CAPTURE: each accepted sample writes all NCH channels at the write address, then the address increments. The write at address DEPTH-1 moves the state to FULL and asserts full on the next cycle.
- FULL: accepted samples are dropped and set overrun.
  - frame_swap in FULL: the banks exchange in the next cycle, full=0, overrun clears, and the state returns to WAIT_TRIG (config re-latched, prev_valid=0).
  - frame_swap in any other state is ignored.
  - If frame_swap and an accepted sample coincide in FULL, the swap wins and the sample is dropped without setting overrun.
- Read port: rd_data is registered from the display bank at rd_addr, 1 cycle latency. rd_addr>=DEPTH returns 0. A bank flip affects reads issued on the cycle after the flip. Reads and writes never touch the same bank.
- Storage: two banks of DEPTH x NCH*SAMPLE_W, inferred synchronous RAM.

Test Plan:
- Free-run, decim=0, NCH=2: ramp ch0=0..639, ch1=1000-ramp&511, then frame_swap → full rises 1 cycle after sample 639; after the swap rd_addr=5 returns ch0=5, ch1=(995)&511 one cycle later.
- Rising, level=100, ch0 sequence 90,95,99,100,… → sample 100 lands at address 0; waiting=0 from the next cycle; auto_trig=0.
- Falling with trig_ch=1, level=50, ch1 constant 200 for AUTO_TO samples → the forced trigger lands on the 2048th accepted sample, auto_trig=1, and that sample is written at address 0.
- decim=3, free-run, valid every cycle → address 0 holds valid sample #4 (counter 0..3), address 1 holds #8; full after 2560 valid cycles.
- FULL held with 3 accepted samples and no swap → overrun=1. Then frame_swap coincident with a sample → overrun=0, waiting=1, and display data switches to the new bank.
- Reset asserted mid-CAPTURE at address 300 → next cycle full=0, waiting=1, display bank=0, rd_data=0, and the next capture starts at address 0.

Source files
------------

// File: rtl/scope_capture_buffer.sv
// Decimated, triggered ping-pong capture buffer feeding the oscilloscope renderer.
// One bank is written by the capture FSM while the other is read out by column address.
module scope_capture_buffer #(
  parameter int unsigned NCH      = 2,
  parameter int unsigned SAMPLE_W = 9,
  parameter int unsigned DEPTH    = 640,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned AUTO_TO  = 2048,
  localparam int unsigned ChW     = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int unsigned DataW   = NCH * SAMPLE_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [DataW-1:0]    sample_data,
  input  logic [1:0]          trig_mode,
  input  logic [ChW-1:0]      trig_ch,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic [7:0]          decim,
  input  logic                frame_swap,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DataW-1:0]    rd_data,
  output logic                full,
  output logic                waiting,
  output logic                auto_trig,
  output logic                overrun
);

  localparam int unsigned ToW = (AUTO_TO > 1) ? $clog2(AUTO_TO) : 1;
  localparam logic [ToW-1:0]    ToLast   = ToW'(AUTO_TO - 1);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef logic [ADDR_W:0] idx_t;
  localparam idx_t DepthIdx = idx_t'(DEPTH);

  typedef enum logic [1:0] {StWaitTrig, StCapture, StFull} state_e;

  state_e              state_q;
  logic                wr_bank_q;
  logic [7:0]          dec_cnt_q;
  logic [ToW-1:0]      to_cnt_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic                prev_valid_q;
  logic [SAMPLE_W-1:0] prev_q;
  logic [1:0]          mode_q;
  logic [ChW-1:0]      trig_ch_q;
  logic [SAMPLE_W-1:0] level_q;
  logic [7:0]          decim_q;

  logic                accept;
  logic [SAMPLE_W-1:0] trig_sample;
  logic                edge_hit;
  logic                timeout;
  logic                fire;
  logic                we;
  logic [ADDR_W-1:0]   wa;
  idx_t                wr_idx;
  idx_t                rd_idx;
  logic                rd_in_range;

  logic [DataW-1:0] mem [2*DEPTH];

  assign accept = sample_valid && (dec_cnt_q == decim_q);

  always_comb begin
    trig_sample = '0;
    for (int k = 0; k < NCH; k++) begin
      if (trig_ch_q == ChW'(k)) trig_sample = sample_data[k*SAMPLE_W +: SAMPLE_W];
    end
  end

  always_comb begin
    edge_hit = 1'b1;
    case (mode_q)
      2'b01:   edge_hit = prev_valid_q && (prev_q < level_q) && (trig_sample >= level_q);
      2'b10:   edge_hit = prev_valid_q && (prev_q >= level_q) && (trig_sample < level_q);
      default: edge_hit = 1'b1;
    endcase
  end

  assign timeout = (to_cnt_q == ToLast);
  assign fire    = accept && (state_q == StWaitTrig) && (edge_hit || timeout);

  // Triggering sample always lands at address 0; capture writes follow at wr_addr_q.
  assign we     = fire || (accept && (state_q == StCapture));
  assign wa     = (state_q == StCapture) ? wr_addr_q : '0;
  assign wr_idx = wr_bank_q ? (DepthIdx + idx_t'(wa)) : idx_t'(wa);
  assign rd_idx = wr_bank_q ? idx_t'(rd_addr) : (DepthIdx + idx_t'(rd_addr));
  assign rd_in_range = (idx_t'(rd_addr) < DepthIdx);

  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= sample_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_in_range) begin
      rd_data <= mem[rd_idx];
    end else begin
      rd_data <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StWaitTrig;
      wr_bank_q    <= 1'b1;
      full         <= 1'b0;
      waiting      <= 1'b1;
      auto_trig    <= 1'b0;
      overrun      <= 1'b0;
      dec_cnt_q    <= '0;
      to_cnt_q     <= '0;
      wr_addr_q    <= '0;
      prev_valid_q <= 1'b0;
      prev_q       <= '0;
      mode_q       <= trig_mode;
      trig_ch_q    <= trig_ch;
      level_q      <= trig_level;
      decim_q      <= decim;
    end else begin
      if (sample_valid) dec_cnt_q <= accept ? 8'd0 : dec_cnt_q + 8'd1;

      unique case (state_q)
        StWaitTrig: begin
          if (accept) begin
            if (edge_hit || timeout) begin
              state_q   <= StCapture;
              wr_addr_q <= ADDR_W'(1);
              waiting   <= 1'b0;
              // A genuine edge wins over a coincident timeout.
              auto_trig <= !edge_hit;
            end else begin
              prev_q       <= trig_sample;
              prev_valid_q <= 1'b1;
              to_cnt_q     <= to_cnt_q + ToW'(1);
            end
          end
        end
        StCapture: begin
          if (accept) begin
            wr_addr_q <= wr_addr_q + ADDR_W'(1);
            if (wr_addr_q == LastAddr) begin
              state_q <= StFull;
              full    <= 1'b1;
            end
          end
        end
        StFull: begin
          if (frame_swap) begin
            state_q      <= StWaitTrig;
            wr_bank_q    <= !wr_bank_q;
            full         <= 1'b0;
            overrun      <= 1'b0;
            waiting      <= 1'b1;
            dec_cnt_q    <= '0;
            to_cnt_q     <= '0;
            wr_addr_q    <= '0;
            prev_valid_q <= 1'b0;
            mode_q       <= trig_mode;
            trig_ch_q    <= trig_ch;
            level_q      <= trig_level;
            decim_q      <= decim;
          end else if (accept) begin
            overrun <= 1'b1;
          end
        end
        default: state_q <= StWaitTrig;
      endcase
    end
  end

endmodule
